// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: Q1..Q4 phase sequencer, ROM fetch, one-deep prefetch into the IR,
// NOP bubbles on flush and interrupt entry. Define IR_PC_TRACE_EN to add the ir_pc trace output.
module instr_fetch_unit #(
    parameter int INSTR_W = 14,
    parameter int ADDR_W  = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  pmem_addr,
    output logic               pmem_rd_en,
    input  logic [INSTR_W-1:0] pmem_data,
    output logic               pc_incr_en,
    input  logic               stall,
    input  logic               flush_req,
    input  logic               irq,
    input  logic               gie,
    output logic               irq_ack,
    output logic [1:0]         q_phase,
    output logic               q_end,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid
`ifdef IR_PC_TRACE_EN
    ,
    output logic [ADDR_W-1:0]  ir_pc
`endif
);

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } qphase_e;

    qphase_e            phase_q, phase_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] buf_q, buf_d;
    logic               flush_q, flush_d;
    logic               irq_pend_q, irq_pend_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic               flush_now;
`ifdef IR_PC_TRACE_EN
    logic [ADDR_W-1:0]  buf_addr_q, buf_addr_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
`endif

    // The ROM address is taken from pc_in on the Q4->Q1 edge so it is stable for the whole of Q1
    // while the read strobe is up; the ROM word then arrives in Q2.
    always_comb begin
        phase_d    = phase_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        flush_d    = flush_q;
        irq_pend_d = irq_pend_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
`ifdef IR_PC_TRACE_EN
        buf_addr_d = buf_addr_q;
        ir_pc_d    = ir_pc_q;
`endif
        flush_now  = flush_q | flush_req;

        if (!stall) begin
            phase_d = qphase_e'(phase_q + 2'd1);
            case (phase_q)
                Q2: begin
                    buf_d = pmem_data;
`ifdef IR_PC_TRACE_EN
                    buf_addr_d = addr_q;
`endif
                end
                Q4: begin
                    addr_d  = pc_in;
                    flush_d = 1'b0;
                    if (flush_now || irq_pend_q) begin
                        ir_d       = '0;
                        ir_valid_d = 1'b0;
                    end else begin
                        ir_d       = buf_q;
                        ir_valid_d = 1'b1;
`ifdef IR_PC_TRACE_EN
                        ir_pc_d    = buf_addr_q;
`endif
                    end
                    // A flush defers interrupt sampling to the next Q4; an entry cycle never re-arms itself.
                    irq_pend_d = !flush_now && !irq_pend_q && irq && gie;
                end
                default: ;
            endcase
            if (phase_q != Q4) begin
                flush_d = flush_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= Q1;
            addr_q     <= '0;
            buf_q      <= '0;
            flush_q    <= 1'b0;
            irq_pend_q <= 1'b0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
`ifdef IR_PC_TRACE_EN
            buf_addr_q <= '0;
            ir_pc_q    <= '0;
`endif
        end else begin
            phase_q    <= phase_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            flush_q    <= flush_d;
            irq_pend_q <= irq_pend_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
`ifdef IR_PC_TRACE_EN
            buf_addr_q <= buf_addr_d;
            ir_pc_q    <= ir_pc_d;
`endif
        end
    end

    // Pulses are decoded from the frozen phase, so a stalled pulse simply reappears once stall drops.
    assign pmem_rd_en = !rst && !stall && (phase_q == Q1);
    assign irq_ack    = !rst && !stall && (phase_q == Q1) && irq_pend_q;
    assign pc_incr_en = !rst && !stall && (phase_q == Q3) && !irq_pend_q;
    assign q_phase    = phase_q;
    assign q_end      = (phase_q == Q4);
    assign pmem_addr  = addr_q;
    assign ir_out     = ir_q;
    assign ir_valid   = ir_valid_q;
`ifdef IR_PC_TRACE_EN
    assign ir_pc      = ir_pc_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: ROM and program-counter environment, a per-instruction-cycle
// reference model checked every clock, and directed scenarios with literal expectations.
module tb_instr_fetch_unit;

   localparam int INSTR_W = 14;
   localparam int ADDR_W  = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst, stall, flush_req, irq, gie;
   logic [ADDR_W-1:0]  pc_in, pmem_addr;
   logic               pmem_rd_en, pc_incr_en, irq_ack, q_end, ir_valid;
   logic [INSTR_W-1:0] pmem_data, ir_out;
   logic [1:0]         q_phase;
`ifdef IR_PC_TRACE_EN
   logic [ADDR_W-1:0]  ir_pc;
`endif

   logic               jump_en;
   logic [ADDR_W-1:0]  jump_val;
   int                 nChecks = 0;
   int                 nPass = 0;
   int                 nIncr = 0;
   int                 n0;

   instr_fetch_unit #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pmem_addr(pmem_addr), .pmem_rd_en(pmem_rd_en),
      .pmem_data(pmem_data), .pc_incr_en(pc_incr_en), .stall(stall), .flush_req(flush_req),
      .irq(irq), .gie(gie), .irq_ack(irq_ack), .q_phase(q_phase), .q_end(q_end),
      .ir_out(ir_out), .ir_valid(ir_valid)
`ifdef IR_PC_TRACE_EN
      , .ir_pc(ir_pc)
`endif
   );

   function automatic logic [INSTR_W-1:0] romWord(input logic [ADDR_W-1:0] a);
      logic [INSTR_W-1:0] w;
      w = INSTR_W'(a);
      return w + INSTR_W'('h100);
   endfunction

   // Synchronous program ROM with one clock of read latency.
   always @(posedge clk) begin
      if (pmem_rd_en) pmem_data <= romWord(pmem_addr);
   end

   // Program counter environment: jumps from the decoder, ISR vector on ack, else increment.
   always @(posedge clk) begin
      if (rst) pc_in <= '0;
      else if (jump_en) pc_in <= jump_val;
      else if (irq_ack) pc_in <= ADDR_W'('h004);
      else if (pc_incr_en) pc_in <= pc_in + 1'b1;
   end

   // Reference model: one instruction cycle is four unstalled clocks; the word loaded at its end
   // is the ROM contents at the address that cycle fetched, unless flushed or an interrupt entry.
   int                 m_phase;
   logic [ADDR_W-1:0]  m_addr, m_irpc;
   logic               m_flush, m_pend, m_valid, m_fl;
   logic [INSTR_W-1:0] m_ir;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_addr = '0; m_irpc = '0; m_flush = 1'b0; m_pend = 1'b0;
         m_valid = 1'b0; m_ir = '0;
      end else if (!stall) begin
         if (m_phase == 3) begin
            m_fl = m_flush || flush_req;
            if (m_fl || m_pend) begin
               m_ir = '0; m_valid = 1'b0;
            end else begin
               m_ir = romWord(m_addr); m_valid = 1'b1; m_irpc = m_addr;
            end
            m_pend  = !m_fl && !m_pend && irq && gie;
            m_flush = 1'b0;
            m_addr  = pc_in;
         end else begin
            m_flush = m_flush || flush_req;
         end
         m_phase = (m_phase + 1) % 4;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      logic live;
      live = !rst && !stall;
      nIncr += int'(pc_incr_en);
      checkOutput("q_phase",    32'(q_phase),    32'(m_phase));
      checkOutput("q_end",      32'(q_end),      32'(m_phase == 3));
      checkOutput("pmem_addr",  32'(pmem_addr),  32'(m_addr));
      checkOutput("pmem_rd_en", 32'(pmem_rd_en), 32'(live && m_phase == 0));
      checkOutput("irq_ack",    32'(irq_ack),    32'(live && m_phase == 0 && m_pend));
      checkOutput("pc_incr_en", 32'(pc_incr_en), 32'(live && m_phase == 2 && !m_pend));
      checkOutput("ir_out",     32'(ir_out),     32'(m_ir));
      checkOutput("ir_valid",   32'(ir_valid),   32'(m_valid));
`ifdef IR_PC_TRACE_EN
      checkOutput("ir_pc",      32'(ir_pc),      32'(m_irpc));
`endif
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic fl, input logic iq, input logic ge);
      stall = st; flush_req = fl; irq = iq; gie = ge;
      tick();
   endtask

   task automatic gotoPhase(input int p);
      for (int i = 0; i < 4; i++) begin
         if (m_phase != p) applyStimulus(1'b0, 1'b0, irq, gie);
      end
   endtask

   // Decoder-style jump: PC is loaded at the end of Q3, so the next Q1 fetches the target.
   task automatic jumpTo(input logic [ADDR_W-1:0] target);
      gotoPhase(2);
      jump_en = 1'b1; jump_val = target;
      applyStimulus(1'b0, 1'b0, irq, gie);
      jump_en = 1'b0;
      applyStimulus(1'b0, 1'b0, irq, gie);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush_req = 1'b0; irq = 1'b0; gie = 1'b0;
      jump_en = 1'b0; jump_val = '0;
      tick(); tick();
      rst = 1'b0;
      checkOutput("reset_q_phase", 32'(q_phase), 32'd0);
      checkOutput("reset_ir_out", 32'(ir_out), 32'd0);
      checkOutput("reset_ir_valid", 32'(ir_valid), 32'd0);
      checkOutput("reset_pmem_addr", 32'(pmem_addr), 32'd0);

      n0 = nIncr;
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("first_ir_out", 32'(ir_out), 32'h100);
      checkOutput("first_ir_valid", 32'(ir_valid), 32'd1);
      repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("run_ir_out", 32'(ir_out), 32'h102);
      checkOutput("run_pmem_addr", 32'(pmem_addr), 32'd3);
      checkOutput("run_incr_count", 32'(nIncr - n0), 32'd3);

      jumpTo(ADDR_W'('h005));
      checkOutput("flush_pmem_addr", 32'(pmem_addr), 32'd5);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      flush_req = 1'b0;
      jump_en = 1'b1; jump_val = ADDR_W'('h020);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      jump_en = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("flush_ir_out", 32'(ir_out), 32'd0);
      checkOutput("flush_ir_valid", 32'(ir_valid), 32'd0);
      checkOutput("flush_target_addr", 32'(pmem_addr), 32'h020);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("after_flush_ir_out", 32'(ir_out), 32'h120);
      checkOutput("after_flush_ir_valid", 32'(ir_valid), 32'd1);

      jumpTo(ADDR_W'('h007));
      gotoPhase(2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      irq = 1'b0;
      checkOutput("irq_ack_q1", 32'(irq_ack), 32'd1);
      checkOutput("irq_prev_ir_out", 32'(ir_out), 32'h107);
      n0 = nIncr;
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("irq_no_incr", 32'(nIncr - n0), 32'd0);
      checkOutput("irq_bubble_valid", 32'(ir_valid), 32'd0);
      checkOutput("irq_isr_addr", 32'(pmem_addr), 32'h004);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("isr_ir_out", 32'(ir_out), 32'h104);

      gotoPhase(3);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      flush_req = 1'b0;
      checkOutput("both_no_ack", 32'(irq_ack), 32'd0);
      checkOutput("both_flush_valid", 32'(ir_valid), 32'd0);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("both_late_ack", 32'(irq_ack), 32'd1);
      irq = 1'b0;
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("both_entry_valid", 32'(ir_valid), 32'd0);

      gotoPhase(2);
      n0 = nIncr;
      stall = 1'b1;
      #1;
      checkOutput("stall_incr_low", 32'(pc_incr_en), 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
         checkOutput("stall_q_phase", 32'(q_phase), 32'd2);
      end
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("stall_one_incr", 32'(nIncr - n0), 32'd1);

      gotoPhase(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      flush_req = 1'b0;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      checkOutput("rst_q_phase", 32'(q_phase), 32'd0);
      checkOutput("rst_ir_valid", 32'(ir_valid), 32'd0);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("rst_no_flush_valid", 32'(ir_valid), 32'd1);
      checkOutput("rst_no_flush_ir", 32'(ir_out), 32'h100);

      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
